// File: rtl/vector_mem_unit.sv
// Vector load/store sequencer: moves one LANES x LANE_W vector between the
// register file and a single-port, one-lane-wide data memory, one lane per cycle.
//
// Request handshake: start is a strobe sampled only while idle (busy=0, done=0).
// A start with opcode VLD or VST is accepted on that edge; any other opcode is
// dropped. busy stays high for the whole memory phase, and done pulses for
// exactly one cycle when the vector has been fully moved. Starts seen while
// busy or done are discarded, not queued.
module vector_mem_unit #(
    parameter int LANES  = 16,
    parameter int LANE_W = 16,
    parameter int ADDR_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [3:0]              opcode,
    input  logic [ADDR_W-1:0]       addr,
    input  logic [LANES*LANE_W-1:0] wdata,
    output logic                    busy,
    output logic                    done,
    output logic [LANES*LANE_W-1:0] rdata,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic                    mem_re,
    output logic                    mem_we,
    output logic [LANE_W-1:0]       mem_wdata,
    input  logic [LANE_W-1:0]       mem_rdata
);

    localparam int IDX_W = $clog2(LANES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

    localparam logic [3:0] OP_VLD = 4'b0100;
    localparam logic [3:0] OP_VST = 4'b0101;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_LWAIT = 3'd2;
    localparam logic [2:0] S_STORE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]              state;
    logic [IDX_W-1:0]        idx;
    logic [ADDR_W-1:0]       base;
    logic [LANES*LANE_W-1:0] wbuf;

    // Memory read data lags the issue by one cycle, so in LOAD the word that
    // arrives belongs to the previous lane (idx-1).
    logic [IDX_W-1:0] cap_lane;
    assign cap_lane = idx - 1'b1;

    // Sequencer state, lane counter, latched request and load capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            idx   <= '0;
            base  <= '0;
            wbuf  <= '0;
            rdata <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && opcode == OP_VLD) begin
                        base  <= addr;
                        idx   <= '0;
                        state <= S_LOAD;
                    end else if (start && opcode == OP_VST) begin
                        base  <= addr;
                        wbuf  <= wdata;
                        idx   <= '0;
                        state <= S_STORE;
                    end
                end
                S_LOAD: begin
                    if (idx != '0) begin
                        rdata[cap_lane*LANE_W +: LANE_W] <= mem_rdata;
                    end
                    idx <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        state <= S_LWAIT;
                    end
                end
                S_LWAIT: begin
                    rdata[(LANES-1)*LANE_W +: LANE_W] <= mem_rdata;
                    state <= S_DONE;
                end
                S_STORE: begin
                    idx <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Status and memory strobes decoded from state; address wraps modulo 2^ADDR_W.
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            S_LOAD: begin
                busy     = 1'b1;
                mem_re   = 1'b1;
                mem_addr = base + ADDR_W'(idx);
            end
            S_LWAIT: begin
                busy = 1'b1;
            end
            S_STORE: begin
                busy      = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = base + ADDR_W'(idx);
                mem_wdata = wbuf[idx*LANE_W +: LANE_W];
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule
